// File: rtl/img_loader.sv
// Frame loader: turns a stream of UART bytes into sequential BRAM port-A writes.
// One write per rising edge of valid_i. The module reports full, busy,
// overflow and a mid-frame idle timeout.
module img_loader #(
    parameter int unsigned DIMENSION      = 64,
    parameter int unsigned ADDR_W         = 14,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_in_n,
    input  logic [7:0]        data_i,
    input  logic              valid_i,
    input  logic              clear_i,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic [7:0]        bram_data_o,
    output logic              bram_we_o,
    output logic              full_o,
    output logic              busy_o,
    output logic              overflow_o,
    output logic              timeout_o
);

    localparam int unsigned Frame = DIMENSION * DIMENSION;
    // The count can hold Frame itself, so it saturates there and never wraps.
    localparam int unsigned CntW = $clog2(Frame + 1);
    localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam int unsigned GapW = TimeoutEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned GapLast = TimeoutEn ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(Frame - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e            state_q;
    logic [CntW-1:0]   count_q;
    logic [GapW-1:0]   gap_q;
    logic              valid_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic              full_q;
    logic              busy_q;
    logic              overflow_q;
    logic              timeout_q;

    logic byte_edge;
    logic last_write;
    logic gap_expired;

    // Byte-edge detection, end-of-frame write and idle-gap expiry decode.
    always_comb begin
        byte_edge   = valid_i & ~valid_q;
        last_write  = we_q && (addr_q == LastAddr);
        // Fires on the clock where the gap counter would reach TIMEOUT_CYCLES.
        gap_expired = TimeoutEn && (gap_q == GapW'(GapLast));
    end

    // Load FSM with all outputs registered; clear_i overrides everything.
    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            gap_q      <= '0;
            // Preset high so a valid_i held through reset release is not a byte.
            valid_q    <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            full_q     <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            valid_q <= valid_i;
            we_q    <= 1'b0;
            if (clear_i) begin
                // A coincident byte edge or timeout is dropped.
                state_q    <= StIdle;
                count_q    <= '0;
                gap_q      <= '0;
                full_q     <= 1'b0;
                busy_q     <= 1'b0;
                overflow_q <= 1'b0;
                timeout_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        gap_q <= '0;
                        if (byte_edge) begin
                            we_q      <= 1'b1;
                            addr_q    <= ADDR_W'(count_q);
                            data_q    <= data_i;
                            count_q   <= count_q + CntW'(1);
                            timeout_q <= 1'b0;
                            busy_q    <= 1'b1;
                            state_q   <= StLoad;
                        end
                    end
                    StLoad: begin
                        if (last_write) begin
                            // No byte edge can coincide: valid_i was high last cycle.
                            state_q <= StDone;
                            full_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            gap_q   <= '0;
                        end else if (byte_edge) begin
                            we_q    <= 1'b1;
                            addr_q  <= ADDR_W'(count_q);
                            data_q  <= data_i;
                            count_q <= count_q + CntW'(1);
                            gap_q   <= '0;
                        end else if (gap_expired) begin
                            // Abandon the partial frame; BRAM keeps stale data.
                            state_q   <= StIdle;
                            count_q   <= '0;
                            gap_q     <= '0;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                        end else if (TimeoutEn) begin
                            gap_q <= gap_q + GapW'(1);
                        end
                    end
                    StDone: begin
                        gap_q <= '0;
                        if (byte_edge) begin
                            overflow_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bram_addr_o = addr_q;
    assign bram_data_o = data_q;
    assign bram_we_o   = we_q;
    assign full_o      = full_q;
    assign busy_o      = busy_q;
    assign overflow_o  = overflow_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_img_loader.sv
// Self-checking bench for img_loader (DIMENSION=4, TIMEOUT_CYCLES=50).
// The reference model works per byte transaction: an expected write list
// plus byte count and flag variables, updated from the loader's rules.
module tb_img_loader;

    localparam int unsigned Dim   = 4;
    localparam int unsigned AddrW = 4;
    localparam int unsigned Tmo   = 50;
    localparam int unsigned Frame = Dim * Dim;

    logic             clk = 1'b0;
    logic             rst_in_n;
    logic [7:0]       data_i;
    logic             valid_i;
    logic             clear_i;
    logic [AddrW-1:0] bram_addr_o;
    logic [7:0]       bram_data_o;
    logic             bram_we_o;
    logic             full_o;
    logic             busy_o;
    logic             overflow_o;
    logic             timeout_o;

    img_loader #(
        .DIMENSION     (Dim),
        .ADDR_W        (AddrW),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clk        (clk),
        .rst_in_n   (rst_in_n),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .clear_i    (clear_i),
        .bram_addr_o(bram_addr_o),
        .bram_data_o(bram_data_o),
        .bram_we_o  (bram_we_o),
        .full_o     (full_o),
        .busy_o     (busy_o),
        .overflow_o (overflow_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state.
    typedef struct packed {
        logic [AddrW-1:0] addr;
        logic [7:0]       data;
    } wr_t;

    wr_t              exp_q[$];
    wr_t              obs_q[$];
    int unsigned      m_count = 0;
    bit               m_full = 0;
    bit               m_ovf = 0;
    bit               m_tmo = 0;
    logic [AddrW-1:0] m_last_addr = '0;

    task automatic model_byte(input logic [7:0] d);
        wr_t w;
        if (m_full) begin
            m_ovf = 1;
        end else begin
            w.addr = AddrW'(m_count);
            w.data = d;
            exp_q.push_back(w);
            m_last_addr = AddrW'(m_count);
            m_count++;
            m_tmo = 0;
            if (m_count == Frame) m_full = 1;
        end
    endtask

    task automatic model_clear();
        m_count = 0;
        m_full  = 0;
        m_ovf   = 0;
        m_tmo   = 0;
    endtask

    // Write monitor: logs each write and checks single-cycle pulses and full timing.
    initial begin
        logic             prev_we;
        logic [AddrW-1:0] prev_addr;
        wr_t              w;
        prev_we   = 1'b0;
        prev_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_in_n) begin
                if (prev_we) check_eq("we_single_cycle", {31'd0, bram_we_o}, 32'd0);
                if (prev_we && prev_addr == AddrW'(Frame - 1)) begin
                    check_eq("full_after_last_write", {31'd0, full_o}, 32'd1);
                    check_eq("busy_after_last_write", {31'd0, busy_o}, 32'd0);
                end
                if (bram_we_o) begin
                    check_eq("full_during_write", {31'd0, full_o}, 32'd0);
                    w.addr = bram_addr_o;
                    w.data = bram_data_o;
                    obs_q.push_back(w);
                end
            end
            prev_we   = rst_in_n ? bram_we_o : 1'b0;
            prev_addr = bram_addr_o;
        end
    end

    task automatic compare_writes(input string tag);
        wr_t o;
        wr_t e;
        check_eq({tag, "_nwrites"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check_eq({tag, "_addr"}, {28'd0, o.addr}, {28'd0, e.addr});
            check_eq({tag, "_data"}, {24'd0, o.data}, {24'd0, e.data});
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_flags(input string tag);
        bit exp_busy;
        exp_busy = (m_count > 0) && !m_full;
        check_eq({tag, "_full"}, {31'd0, full_o}, {31'd0, m_full});
        check_eq({tag, "_busy"}, {31'd0, busy_o}, {31'd0, exp_busy});
        check_eq({tag, "_ovf"}, {31'd0, overflow_o}, {31'd0, m_ovf});
        check_eq({tag, "_tmo"}, {31'd0, timeout_o}, {31'd0, m_tmo});
        check_eq({tag, "_addr_hold"}, {28'd0, bram_addr_o}, {28'd0, m_last_addr});
        check_eq({tag, "_we_idle"}, {31'd0, bram_we_o}, 32'd0);
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic send_byte(input logic [7:0] d, input int hold, input int gap);
        data_i  = d;
        valid_i = 1'b1;
        repeat (hold) @(negedge clk);
        valid_i = 1'b0;
        data_i  = 8'($urandom);
        repeat (gap) @(negedge clk);
        model_byte(d);
    endtask

    task automatic do_clear(input string tag);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        model_clear();
        @(negedge clk);
        check_flags(tag);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_addr"}, {28'd0, bram_addr_o}, 32'd0);
        check_eq({tag, "_data"}, {24'd0, bram_data_o}, 32'd0);
        check_eq({tag, "_we"}, {31'd0, bram_we_o}, 32'd0);
        check_eq({tag, "_flags"}, {28'd0, full_o, busy_o, overflow_o, timeout_o}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         n;
        rst_in_n = 1'b1;
        valid_i  = 1'b1;
        clear_i  = 1'b0;
        data_i   = 8'h00;
        #3 rst_in_n = 1'b0;
        #1 check_zero_outputs("reset");

        // Release reset with valid_i held high: must not count as a byte.
        repeat (3) @(negedge clk);
        #2 rst_in_n = 1'b1;
        repeat (4) @(negedge clk);
        valid_i = 1'b0;
        repeat (2) @(negedge clk);
        compare_writes("rst_valid_held");
        check_flags("rst_valid_held");

        // Full frame, valid_i held 3 cycles per byte.
        for (int i = 0; i < Frame; i++) begin
            send_byte(8'(i), 3, 1);
            check_flags("frame_seq");
        end
        compare_writes("frame_seq");

        // Byte after full.
        send_byte(8'h10, 2, 2);
        compare_writes("overflow");
        check_flags("overflow");

        // Five bytes then a long idle gap.
        do_clear("clear_after_ovf");
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1, 2);
        d = 8'($urandom);
        data_i  = d;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        model_byte(d);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            valid_i = 1'b0;
            @(posedge clk);
            #1;
            if (k == Tmo - 1) begin
                check_eq("tmo_before_limit", {31'd0, timeout_o}, 32'd0);
                check_eq("busy_before_limit", {31'd0, busy_o}, 32'd1);
            end
            if (k == Tmo) begin
                check_eq("tmo_at_limit", {31'd0, timeout_o}, 32'd1);
                check_eq("busy_at_limit", {31'd0, busy_o}, 32'd0);
            end
        end
        m_count = 0;
        m_tmo   = 1;
        @(negedge clk);
        check_flags("timeout");
        compare_writes("timeout_pre");
        send_byte(8'hAA, 2, 1);
        compare_writes("after_timeout");
        check_flags("after_timeout");

        // clear_i coinciding with a byte edge at count 7.
        do_clear("clear_after_tmo");
        for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1, 1);
        compare_writes("pre_clear7");
        data_i  = 8'($urandom);
        valid_i = 1'b1;
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        valid_i = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        compare_writes("clear_vs_edge");
        check_flags("clear_vs_edge");
        send_byte(8'h5C, 1, 1);
        compare_writes("after_clear_edge");

        // Asynchronous reset mid-frame at count 9.
        do_clear("clear_pre_rst");
        for (int i = 0; i < 9; i++) send_byte(8'($urandom), 2, 1);
        compare_writes("pre_rst9");
        #3;
        rst_in_n = 1'b0;
        valid_i  = 1'b1;
        #1 check_zero_outputs("async_rst");
        model_clear();
        m_last_addr = '0;
        repeat (2) @(negedge clk);
        #4 rst_in_n = 1'b1;
        repeat (3) @(negedge clk);
        valid_i = 1'b0;
        repeat (2) @(negedge clk);
        compare_writes("rst_release");
        check_flags("rst_release");
        send_byte(8'h3E, 1, 1);
        compare_writes("after_rst");

        // Back-to-back edges two cycles apart through a whole frame.
        do_clear("clear_pre_b2b");
        for (int i = 0; i < Frame; i++) send_byte(8'($urandom), 1, 1);
        compare_writes("b2b");
        check_flags("b2b");

        // Randomised frames, some running past full.
        for (int it = 0; it < 6; it++) begin
            do_clear("rand_clear");
            n = $urandom_range(1, Frame + 2);
            for (int i = 0; i < n; i++) begin
                send_byte(8'($urandom), $urandom_range(1, 3), $urandom_range(1, 3));
            end
            compare_writes("rand");
            check_flags("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
